// File: rtl/seg_pkg.sv
// Shared constants, segment glyphs and conversion FSM state type for the
// 6-digit multiplexed 7-segment scan controller.
package seg_pkg;

  localparam int unsigned NUM_DIG = 6;
  localparam int unsigned BIN_W   = 20;
  localparam int unsigned BCD_W   = 4 * NUM_DIG;

  localparam logic [BIN_W-1:0] MAX_UNSIGNED = 20'd999_999;
  localparam logic [BIN_W-1:0] MAX_SIGNED   = 20'd99_999;

  // Active-low, bit 7 = dp, bits 6:0 = gfedcba
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  function automatic logic [6:0] glyph7(input logic [3:0] nib);
    case (nib)
      4'd0:    glyph7 = SEG_0[6:0];
      4'd1:    glyph7 = SEG_1[6:0];
      4'd2:    glyph7 = SEG_2[6:0];
      4'd3:    glyph7 = SEG_3[6:0];
      4'd4:    glyph7 = SEG_4[6:0];
      4'd5:    glyph7 = SEG_5[6:0];
      4'd6:    glyph7 = SEG_6[6:0];
      4'd7:    glyph7 = SEG_7[6:0];
      4'd8:    glyph7 = SEG_8[6:0];
      4'd9:    glyph7 = SEG_9[6:0];
      default: glyph7 = SEG_BLANK[6:0];
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: 20-bit binary to 6 BCD nibbles, one bit per clock.
// start_i loads the operand; done_o flags the cycle of the final shift.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic             done_o
);

  logic             run_q;
  logic [4:0]       cnt_q;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj;

  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < NUM_DIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Combinational so the parent can leave SHIFT on the same edge as the last shift
  assign done_o = run_q && (cnt_q == 5'(BIN_W - 1));
  assign bcd_o  = bcd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      bin_q <= bin_i;
      bcd_q <= '0;
    end else if (run_q) begin
      bcd_q <= {adj[BCD_W-2:0], bin_q[BIN_W-1]};
      bin_q <= {bin_q[BIN_W-2:0], 1'b0};
      cnt_q <= cnt_q + 5'd1;
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 6-digit common-anode 7-segment scan controller with sequential BCD conversion.
// Define LEADING_ZERO_BLANK_EN to blank zero digits left of the most significant digit.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50_000,
  parameter int unsigned NUM_DIG  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [19:0]        data,
  input  logic [NUM_DIG-1:0] point,
  input  logic               en,
  input  logic               sign,
  output logic [NUM_DIG-1:0] seg_sel,
  output logic [7:0]         seg_led,
  output logic               busy
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_e             state_q;
  logic               busy_q;
  logic               snap_vld_q;
  logic [19:0]        snap_data_q;
  logic               snap_sign_q;
  logic [NUM_DIG-1:0] snap_point_q;
  logic [BCD_W-1:0]   bcd_c_q;
  logic [NUM_DIG-1:0] point_c_q;
  logic               sign_c_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         idx_q;
  logic [NUM_DIG-1:0] sel_q;
  logic [7:0]         led_q;

  logic               changed;
  logic               start;
  logic [19:0]        clamped;
  logic [BCD_W-1:0]   bcd;
  logic               bcd_done;
  logic [3:0]         nib;
  logic [7:0]         glyph_d;
  logic [NUM_DIG-1:0] sel_d;

  // snap_vld_q forces one conversion after reset even when the inputs are all zero
  assign changed = !snap_vld_q ||
                   ({data, sign, point} != {snap_data_q, snap_sign_q, snap_point_q});
  assign start   = (state_q == IDLE) && changed;

  always_comb begin
    clamped = data;
    if (sign && (data > MAX_SIGNED)) clamped = MAX_SIGNED;
    else if (data > MAX_UNSIGNED)    clamped = MAX_UNSIGNED;
  end

  bin2bcd_seq u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .start_i(start),
    .bin_i  (clamped),
    .bcd_o  (bcd),
    .done_o (bcd_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      snap_vld_q   <= 1'b0;
      snap_data_q  <= '0;
      snap_sign_q  <= 1'b0;
      snap_point_q <= '0;
      bcd_c_q      <= '0;
      point_c_q    <= '0;
      sign_c_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (changed) begin
          snap_vld_q   <= 1'b1;
          snap_data_q  <= data;
          snap_sign_q  <= sign;
          snap_point_q <= point;
          busy_q       <= 1'b1;
          state_q      <= SHIFT;
        end
        SHIFT: if (bcd_done) state_q <= DONE;
        DONE: begin
          bcd_c_q   <= bcd;
          point_c_q <= snap_point_q;
          sign_c_q  <= snap_sign_q;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    nib     = 4'(bcd_c_q >> {idx_q, 2'b00});
    glyph_d = {~point_c_q[idx_q], glyph7(nib)};
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic blank;
      blank = (idx_q != 3'd0);
      for (int unsigned j = 0; j < NUM_DIG; j++) begin
        if ((j >= 32'(idx_q)) && ((bcd_c_q[4*j +: 4] != 4'd0) || point_c_q[j])) blank = 1'b0;
      end
      if (blank) glyph_d = SEG_BLANK;
    end
`endif
    if (sign_c_q && (idx_q == 3'(NUM_DIG - 1))) glyph_d = {~point_c_q[idx_q], SEG_MINUS[6:0]};
    sel_d = ~(NUM_DIG'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      sel_q <= '1;
      led_q <= '1;
    end else begin
      if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
        cnt_q <= '0;
        idx_q <= (idx_q == 3'(NUM_DIG - 1)) ? 3'd0 : idx_q + 3'd1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      sel_q <= en ? sel_d : '1;
      led_q <= en ? glyph_d : '1;
    end
  end

  assign seg_sel = sel_q;
  assign seg_led = led_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (SCAN_DIV=4): stimulus queues expectations,
// a negedge monitor matches them against the DUT outputs.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] data = '0;
  logic [5:0]  point = '0;
  logic        en = 1'b1;
  logic        sign = 1'b0;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_led;
  logic        busy;

  seg_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .point  (point),
    .en     (en),
    .sign   (sign),
    .seg_sel(seg_sel),
    .seg_led(seg_led),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef enum int {K_NOW, K_DIGIT, K_BUSY} kind_e;
  typedef struct {
    kind_e      kind;
    string      name;
    int         at;
    logic [5:0] sel;
    logic [7:0] led;
    bit         chk_busy;
    logic       bsy;
    int         len;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         since_rst = 0;
  int         run_len = 0;
  int         waited = 0;
  logic [7:0] cur_led[6];

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    since_rst <= rst ? 0 : since_rst + 1;
  end

  // Monitor: at most one queue entry resolved per negedge
  always @(negedge clk) begin
    bit   fell;
    int   flen;
    bit   hit;
    exp_t e;
    fell = 0;
    flen = 0;
    hit  = 0;
    if (busy === 1'b1) run_len++;
    else if (run_len > 0) begin
      fell = 1; flen = run_len; run_len = 0;
    end
    if (q.size() > 0) begin
      e = q[0];
      case (e.kind)
        K_NOW: if (cyc > e.at) begin
          hit = 1; n_cmp++;
          if (seg_sel !== e.sel || seg_led !== e.led || (e.chk_busy && busy !== e.bsy)) begin
            n_bad++;
            $display("FAIL %s: got sel=%h led=%h busy=%b, want sel=%h led=%h busy=%b%s",
                     e.name, seg_sel, seg_led, busy, e.sel, e.led, e.bsy,
                     e.chk_busy ? "" : " (busy not checked)");
          end
        end
        K_DIGIT: if (seg_sel === e.sel) begin
          hit = 1; n_cmp++;
          if (seg_led !== e.led) begin
            n_bad++;
            $display("FAIL %s: sel=%h got led=%h, want led=%h", e.name, seg_sel, seg_led, e.led);
          end
        end
        K_BUSY: if (fell) begin
          hit = 1; n_cmp++;
          if (flen != e.len) begin
            n_bad++;
            $display("FAIL %s: busy high %0d cycles, want %0d", e.name, flen, e.len);
          end
        end
        default: hit = 1;
      endcase
      if (hit) begin
        void'(q.pop_front());
        waited = 0;
      end else if (++waited > 300) begin
        n_cmp++; n_bad++;
        $display("FAIL %s: timeout waiting for DUT, got sel=%h busy=%b, want sel=%h",
                 e.name, seg_sel, busy, e.sel);
        void'(q.pop_front());
        waited = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_now(input string nm, input logic [5:0] s, input logic [7:0] l,
                          input bit cb, input logic b);
    exp_t e;
    e.kind = K_NOW; e.name = nm; e.at = cyc; e.sel = s; e.led = l;
    e.chk_busy = cb; e.bsy = b; e.len = 0;
    q.push_back(e);
  endtask

  task automatic push_busy(input string nm, input int n);
    exp_t e;
    e.kind = K_BUSY; e.name = nm; e.at = cyc; e.sel = '0; e.led = '0;
    e.chk_busy = 0; e.bsy = 0; e.len = n;
    q.push_back(e);
  endtask

  task automatic push_digits(input string nm);
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      e.kind = K_DIGIT; e.name = $sformatf("%s_d%0d", nm, i); e.at = cyc;
      e.sel = 6'(~(6'b1 << i)); e.led = cur_led[i];
      e.chk_busy = 0; e.bsy = 0; e.len = 0;
      q.push_back(e);
    end
  endtask

  task automatic set_all(input logic [7:0] g);
    for (int i = 0; i < 6; i++) cur_led[i] = g;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() > 0 && n < 2000) begin tick(); n++; end
    if (q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d entries pending, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_busy();
    int n = 0;
    while (busy !== 1'b1 && n < 100) begin tick(); n++; end
    if (busy !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL busy_start: got busy=%b, want 1", busy);
    end
  endtask

  initial begin
    int idx;
    // 1: reset values, first conversion after release
    tick(); tick();
    push_now("reset", 6'h3F, 8'hFF, 1, 1'b0);
    tick();
    wait_empty();
    push_busy("busy_len_first", 21);
    rst = 1'b0;
    wait_empty();
`ifdef LEADING_ZERO_BLANK_EN
    set_all(8'hFF); cur_led[0] = 8'hC0;
`else
    set_all(8'hC0);
`endif
    push_digits("zero");
    wait_empty();

    // 2: plain value
    push_busy("busy_len_123456", 21);
    data = 20'd123456;
    wait_empty();
    cur_led[0] = 8'h82; cur_led[1] = 8'h92; cur_led[2] = 8'h99;
    cur_led[3] = 8'hB0; cur_led[4] = 8'hA4; cur_led[5] = 8'hF9;
    push_digits("v123456");
    wait_empty();

    // 3: clamps
    push_busy("busy_len_max", 21);
    data = 20'hFFFFF;
    wait_empty();
    set_all(8'h90);
    push_digits("clamp_unsigned");
    wait_empty();
    push_busy("busy_len_sign", 21);
    sign = 1'b1; data = 20'd123456;
    wait_empty();
    set_all(8'h90); cur_led[5] = 8'hBF;
    push_digits("clamp_signed");
    wait_empty();

    // 4: decimal point, then enable gating while the scan keeps running
    push_busy("busy_len_point", 21);
    sign = 1'b0; point = 6'b000100;
    wait_empty();
    cur_led[0] = 8'h82; cur_led[1] = 8'h92; cur_led[2] = 8'h19;
    cur_led[3] = 8'hB0; cur_led[4] = 8'hA4; cur_led[5] = 8'hF9;
    push_digits("point2");
    wait_empty();
    en = 1'b0;
    push_now("en_off", 6'h3F, 8'hFF, 0, 1'b0);
    wait_empty();
    for (int k = 0; k < 9; k++) begin
      push_now($sformatf("en_off_hold%0d", k), 6'h3F, 8'hFF, 0, 1'b0);
      wait_empty();
    end
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      idx = (since_rst / 4) % 6;
      push_now($sformatf("en_on_scan%0d", k), 6'(~(6'b1 << idx)), cur_led[idx], 0, 1'b0);
      wait_empty();
    end

    // 5a: input change during a conversion is picked up afterwards
    push_busy("busy_len_mid1", 21);
    push_busy("busy_len_mid2", 21);
    point = '0; data = 20'd111111;
    wait_busy();
    repeat (5) tick();
    data = 20'd222222;
    wait_empty();
    set_all(8'hA4);
    push_digits("mid_second");
    wait_empty();

    // 5b: reset in the middle of SHIFT discards the conversion
    data = 20'd333333;
    wait_busy();
    repeat (10) tick();
    push_now("mid_reset", 6'h3F, 8'hFF, 1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_now("post_reset_digit0", 6'h3E, 8'hC0, 1, 1'b1);
    wait_empty();
    push_busy("busy_len_after_reset", 21);
    wait_empty();
    set_all(8'hB0);
    push_digits("after_reset");
    wait_empty();

`ifdef LEADING_ZERO_BLANK_EN
    // 6: leading zero blanking
    push_busy("busy_len_42", 21);
    data = 20'd42;
    wait_empty();
    set_all(8'hFF); cur_led[0] = 8'hA4; cur_led[1] = 8'h99;
    push_digits("blank42");
    wait_empty();
    push_busy("busy_len_0", 21);
    data = 20'd0;
    wait_empty();
    set_all(8'hFF); cur_led[0] = 8'hC0;
    push_digits("blank0");
    wait_empty();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
